// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared constants and types for the two-requester DDR3 read-port arbiter.
package ddr_rd_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         ARB_ID_W       = 32'sd8;
  localparam int         DEF_MAX_OUT    = 32'sd4;
  localparam int         CNT_W          = 32'sd3;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

  function automatic logic [ARB_ID_W-1:0] make_arid(input logic req);
    make_arid = {{(ARB_ID_W-1){1'b0}}, req};
  endfunction

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// Requester-side and controller-side read channels of the arbiter, bundled.
interface ddr_rd_arbiter_if
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH      = 128
);
  logic                       ddr_init_done;

  logic [CTRL_ADDR_WIDTH-1:0] m0_araddr;
  logic [7:0]                 m0_arlen;
  logic                       m0_arvalid;
  logic                       m0_arready;
  logic [DATA_WIDTH-1:0]      m0_rdata;
  logic                       m0_rvalid;
  logic                       m0_rlast;
  logic                       m0_rready;

  logic [CTRL_ADDR_WIDTH-1:0] m1_araddr;
  logic [7:0]                 m1_arlen;
  logic                       m1_arvalid;
  logic                       m1_arready;
  logic [DATA_WIDTH-1:0]      m1_rdata;
  logic                       m1_rvalid;
  logic                       m1_rlast;
  logic                       m1_rready;

  logic [31:0]                axi_araddr;
  logic [ARB_ID_W-1:0]        axi_arid;
  logic [7:0]                 axi_arlen;
  logic [2:0]                 axi_arsize;
  logic [1:0]                 axi_arburst;
  logic                       axi_arvalid;
  logic                       axi_arready;
  logic [DATA_WIDTH-1:0]      axi_rdata;
  logic [ARB_ID_W-1:0]        axi_rid;
  logic                       axi_rlast;
  logic                       axi_rvalid;
  logic                       axi_rready;

  logic                       protocol_err;

  // arbiter view
  modport slave (
    input  ddr_init_done,
    input  m0_araddr, m0_arlen, m0_arvalid, m0_rready,
    output m0_arready, m0_rdata, m0_rvalid, m0_rlast,
    input  m1_araddr, m1_arlen, m1_arvalid, m1_rready,
    output m1_arready, m1_rdata, m1_rvalid, m1_rlast,
    output axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rid, axi_rlast, axi_rvalid,
    output axi_rready,
    output protocol_err
  );

  // requesters plus controller, as seen from outside the arbiter
  modport master (
    output ddr_init_done,
    output m0_araddr, m0_arlen, m0_arvalid, m0_rready,
    input  m0_arready, m0_rdata, m0_rvalid, m0_rlast,
    output m1_araddr, m1_arlen, m1_arvalid, m1_rready,
    input  m1_arready, m1_rdata, m1_rvalid, m1_rlast,
    input  axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rid, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  protocol_err
  );

endinterface

// File: rtl/ddr_arb_out_cnt.sv
// Outstanding-burst counter for one requester; saturates at MAX_OUT and at zero.
module ddr_arb_out_cnt
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // next count: a simultaneous inc and dec cancel out
  always_comb begin
    count_nxt_s = count_r;
    if (inc && !dec) begin
      if (count_r < LIMIT) begin
        count_nxt_s = count_r + 3'd1;
      end else begin
        count_nxt_s = count_r;
      end
    end else if (dec && !inc) begin
      if (count_r != 3'd0) begin
        count_nxt_s = count_r - 3'd1;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 3'd0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign full      = (count_r >= LIMIT);
  assign underflow = dec && (count_r == 3'd0);

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter merging two read requesters onto DDR3 controller port 0.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUT         = DEF_MAX_OUT
) (
  input logic             clk,
  input logic             rst,
  ddr_rd_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  ar_state_t                  state_r;
  ar_state_t                  state_nxt_s;
  logic                       rr_ptr_r;
  logic                       arvalid_r;
  logic [31:0]                araddr_r;
  logic [ARB_ID_W-1:0]        arid_r;
  logic [7:0]                 arlen_r;
  logic                       protocol_err_r;

  logic                       gnt_vld_s;
  logic                       gnt_id_s;
  logic [CTRL_ADDR_WIDTH-1:0] gnt_addr_s;
  logic [7:0]                 gnt_len_s;
  logic                       elig0_s;
  logic                       elig1_s;
  logic                       ar_acc_s;
  logic                       sel_s;
  logic                       r_end_s;
  logic                       inc0_s;
  logic                       inc1_s;
  logic                       dec0_s;
  logic                       dec1_s;
  logic [CNT_W-1:0]           cnt0_s;
  logic [CNT_W-1:0]           cnt1_s;
  logic                       full0_s;
  logic                       full1_s;
  logic                       uf0_s;
  logic                       uf1_s;

  assign elig0_s    = bus.m0_arvalid && (cnt0_s < MAX_OUT_C) && bus.ddr_init_done;
  assign elig1_s    = bus.m1_arvalid && (cnt1_s < MAX_OUT_C) && bus.ddr_init_done;
  assign gnt_addr_s = gnt_id_s ? bus.m1_araddr : bus.m0_araddr;
  assign gnt_len_s  = gnt_id_s ? bus.m1_arlen  : bus.m0_arlen;
  assign ar_acc_s   = (state_r == AR_ISSUE) && bus.axi_arready;

  // AR next-state and grant decode; grants only happen in IDLE
  always_comb begin
    state_nxt_s = state_r;
    gnt_vld_s   = 1'b0;
    gnt_id_s    = 1'b0;
    if (rst) begin
      state_nxt_s = AR_IDLE;
    end else begin
      case (state_r)
        AR_IDLE: begin
          if (elig0_s && elig1_s) begin
            gnt_vld_s   = 1'b1;
            gnt_id_s    = rr_ptr_r;
            state_nxt_s = AR_ISSUE;
          end else if (elig0_s) begin
            gnt_vld_s   = 1'b1;
            gnt_id_s    = 1'b0;
            state_nxt_s = AR_ISSUE;
          end else if (elig1_s) begin
            gnt_vld_s   = 1'b1;
            gnt_id_s    = 1'b1;
            state_nxt_s = AR_ISSUE;
          end else begin
            state_nxt_s = AR_IDLE;
          end
        end
        AR_ISSUE: begin
          if (bus.axi_arready) begin
            state_nxt_s = AR_IDLE;
          end else begin
            state_nxt_s = AR_ISSUE;
          end
        end
        default: state_nxt_s = AR_IDLE;
      endcase
    end
  end

  // AR state, captured request and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= AR_IDLE;
      rr_ptr_r  <= 1'b0;
      arvalid_r <= 1'b0;
      araddr_r  <= 32'd0;
      arid_r    <= 8'd0;
      arlen_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_vld_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= 32'(gnt_addr_s);
        arid_r    <= make_arid(gnt_id_s);
        arlen_r   <= gnt_len_s;
      end else if (ar_acc_s) begin
        arvalid_r <= 1'b0;
        rr_ptr_r  <= ~arid_r[0];
      end
    end
  end

  assign bus.m0_arready  = gnt_vld_s && !gnt_id_s;
  assign bus.m1_arready  = gnt_vld_s && gnt_id_s;
  assign bus.axi_arvalid = arvalid_r;
  assign bus.axi_araddr  = araddr_r;
  assign bus.axi_arid    = arid_r;
  assign bus.axi_arlen   = arlen_r;
  assign bus.axi_arsize  = AXI_SIZE_16B;
  assign bus.axi_arburst = AXI_BURST_INCR;

  // R channel routed purely on the low ID bit
  assign sel_s          = bus.axi_rid[0];
  assign bus.m0_rdata   = bus.axi_rdata;
  assign bus.m1_rdata   = bus.axi_rdata;
  assign bus.m0_rvalid  = bus.axi_rvalid && !sel_s;
  assign bus.m1_rvalid  = bus.axi_rvalid && sel_s;
  assign bus.m0_rlast   = bus.axi_rlast && !sel_s;
  assign bus.m1_rlast   = bus.axi_rlast && sel_s;
  assign bus.axi_rready = sel_s ? bus.m1_rready : bus.m0_rready;

  assign r_end_s = bus.axi_rvalid && bus.axi_rready && bus.axi_rlast;
  assign inc0_s  = ar_acc_s && !arid_r[0] && !full0_s;
  assign inc1_s  = ar_acc_s && arid_r[0] && !full1_s;
  assign dec0_s  = r_end_s && !sel_s;
  assign dec1_s  = r_end_s && sel_s;

  ddr_arb_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc0_s),
    .dec       (dec0_s),
    .count     (cnt0_s),
    .full      (full0_s),
    .underflow (uf0_s)
  );

  ddr_arb_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc1_s),
    .dec       (dec1_s),
    .count     (cnt1_s),
    .full      (full1_s),
    .underflow (uf1_s)
  );

  // sticky flag for a burst end nobody was waiting for
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err_r <= 1'b0;
    end else begin
      protocol_err_r <= protocol_err_r || uf0_s || uf1_s;
    end
  end

  assign bus.protocol_err = protocol_err_r;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Randomised and scenario bench for ddr_rd_arbiter against a transaction-level reference model.
module tb_ddr_rd_arbiter;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ddr_rd_arbiter_if #(.CTRL_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr_rd_arbiter #(.CTRL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          id;
  } ar_t;

  ar_t  ar_q[$];
  int   m_cnt[2];
  int   m_rr;
  bit   m_perr;
  int   gnt_log[$];
  int   arid_log[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [1:0]  obs_gnt;
  logic        obs_arvalid;
  logic [31:0] obs_araddr;
  logic [7:0]  obs_arid;
  logic [7:0]  obs_arlen;
  logic        obs_perr;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ddr_init_done = 1'b1;
    bus.m0_araddr = '0; bus.m0_arlen = 8'd0; bus.m0_arvalid = 1'b0; bus.m0_rready = 1'b1;
    bus.m1_araddr = '0; bus.m1_arlen = 8'd0; bus.m1_arvalid = 1'b0; bus.m1_rready = 1'b1;
    bus.axi_arready = 1'b1;
    bus.axi_rdata = '0; bus.axi_rid = 8'd0; bus.axi_rlast = 1'b0; bus.axi_rvalid = 1'b0;
  endtask

  // One clock: compare DUT with the model at the falling edge, then advance the model.
  task automatic step();
    bit   pend, el0, el1, gv, sel, acc, rend;
    int   gid;
    logic rrdy;
    @(negedge clk);
    obs_gnt     = {bus.m1_arready, bus.m0_arready};
    obs_arvalid = bus.axi_arvalid;
    obs_araddr  = bus.axi_araddr;
    obs_arid    = bus.axi_arid;
    obs_arlen   = bus.axi_arlen;
    obs_perr    = bus.protocol_err;
    if (bus.m0_arready || bus.m1_arready) gnt_log.push_back(bus.m1_arready ? 1 : 0);
    if (bus.axi_arvalid && bus.axi_arready) arid_log.push_back(int'(bus.axi_arid[0]));

    pend = (ar_q.size() != 0);
    check_eq("axi_arvalid", bus.axi_arvalid, pend);
    if (pend) begin
      check_eq("axi_araddr", bus.axi_araddr, ar_q[0].addr);
      check_eq("axi_arlen", bus.axi_arlen, ar_q[0].len);
      check_eq("axi_arid", bus.axi_arid, 8'(ar_q[0].id));
    end
    check_eq("axi_arsize", bus.axi_arsize, 3'd4);
    check_eq("axi_arburst", bus.axi_arburst, 2'b01);
    check_eq("protocol_err", bus.protocol_err, m_perr);

    el0 = bus.m0_arvalid && (m_cnt[0] < MAXO) && bus.ddr_init_done && !pend;
    el1 = bus.m1_arvalid && (m_cnt[1] < MAXO) && bus.ddr_init_done && !pend;
    gv  = el0 || el1;
    gid = (el0 && el1) ? m_rr : (el1 ? 1 : 0);
    check_eq("m0_arready", bus.m0_arready, gv && gid == 0);
    check_eq("m1_arready", bus.m1_arready, gv && gid == 1);

    sel  = bus.axi_rid[0];
    rrdy = sel ? bus.m1_rready : bus.m0_rready;
    check_eq("m0_rvalid", bus.m0_rvalid, bus.axi_rvalid && !sel);
    check_eq("m1_rvalid", bus.m1_rvalid, bus.axi_rvalid && sel);
    check_eq("m0_rlast", bus.m0_rlast, bus.axi_rlast && !sel);
    check_eq("m1_rlast", bus.m1_rlast, bus.axi_rlast && sel);
    check_eq("axi_rready", bus.axi_rready, rrdy);
    check_eq("m0_rdata", bus.m0_rdata, bus.axi_rdata);
    check_eq("m1_rdata", bus.m1_rdata, bus.axi_rdata);

    acc  = pend && bus.axi_arready;
    rend = bus.axi_rvalid && rrdy && bus.axi_rlast;
    for (int n = 0; n < 2; n++) begin
      int inc, dec;
      inc = 0;
      if (acc) inc = (ar_q[0].id == n) ? 1 : 0;
      dec = (rend && (int'(sel) == n)) ? 1 : 0;
      if (dec == 1 && m_cnt[n] == 0) m_perr = 1'b1;
      else m_cnt[n] = m_cnt[n] + inc - dec;
    end
    if (acc) begin
      m_rr = 1 - ar_q[0].id;
      void'(ar_q.pop_front());
    end
    if (gv) begin
      ar_t t;
      t.addr = (gid == 1) ? 32'(bus.m1_araddr) : 32'(bus.m0_araddr);
      t.len  = (gid == 1) ? bus.m1_arlen : bus.m0_arlen;
      t.id   = gid;
      ar_q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with requests pending, checking every registered output stays cleared.
  task automatic do_reset();
    idle_inputs();
    bus.m0_arvalid = 1'b1;
    bus.m1_arvalid = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_m0_arready", bus.m0_arready, 1'b0);
      check_eq("rst_m1_arready", bus.m1_arready, 1'b0);
      check_eq("rst_arvalid", bus.axi_arvalid, 1'b0);
      check_eq("rst_araddr", bus.axi_araddr, 32'd0);
      check_eq("rst_arid", bus.axi_arid, 8'd0);
      check_eq("rst_arlen", bus.axi_arlen, 8'd0);
      check_eq("rst_perr", bus.protocol_err, 1'b0);
    end
    ar_q.delete();
    m_cnt = '{0, 0};
    m_rr = 0;
    m_perr = 1'b0;
    gnt_log.delete();
    arid_log.delete();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    int r;
    logic [31:0] tmp;
    bus.ddr_init_done = ($urandom_range(0, 15) != 0);
    bus.m0_arvalid = 1'($urandom_range(0, 1));
    bus.m1_arvalid = 1'($urandom_range(0, 1));
    bus.m0_araddr  = AW'($urandom);
    bus.m1_araddr  = AW'($urandom);
    bus.m0_arlen   = 8'($urandom);
    bus.m1_arlen   = 8'($urandom);
    bus.axi_arready = ($urandom_range(0, 2) != 0);
    bus.m0_rready  = ($urandom_range(0, 3) != 0);
    bus.m1_rready  = ($urandom_range(0, 3) != 0);
    bus.axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
    r = int'($urandom_range(0, 1));
    if (m_cnt[r] == 0) r = 1 - r;
    bus.axi_rvalid = (m_cnt[r] != 0) && ($urandom_range(0, 1) == 1);
    if ($urandom_range(0, 499) == 0) bus.axi_rvalid = 1'b1;
    tmp = $urandom;
    bus.axi_rid   = {tmp[6:0], r[0]};
    bus.axi_rlast = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    idle_inputs();

    // single requester, controller always ready
    do_reset();
    bus.m0_araddr = 28'h100; bus.m0_arlen = 8'd7; bus.m0_arvalid = 1'b1;
    step();
    check_eq("s1_grant", obs_gnt, 2'b01);
    bus.m0_arvalid = 1'b0;
    step();
    check_eq("s1_gnt_once", obs_gnt, 2'b00);
    check_eq("s1_araddr", obs_araddr, 32'h100);
    check_eq("s1_arid", obs_arid, 8'd0);
    check_eq("s1_arlen", obs_arlen, 8'd7);
    check_eq("s1_out_cnt0", dut.u_cnt0.count, 3'd1);

    // both requesting continuously: grants alternate
    do_reset();
    bus.m0_arvalid = 1'b1; bus.m1_arvalid = 1'b1;
    bus.m0_araddr = 28'h0AAA000; bus.m1_araddr = 28'h0BBB000;
    repeat (8) step();
    check_eq("s2_ngrants", gnt_log.size(), 4);
    check_eq("s2_naccepts", arid_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) check_eq("s2_grant_order", gnt_log[k], k % 2);
      if (k < arid_log.size()) check_eq("s2_arid_order", arid_log[k], k % 2);
    end

    // m1 saturates at MAX_OUT, m0 unaffected, one rlast reopens m1
    do_reset();
    bus.m1_arvalid = 1'b1; bus.m1_araddr = 28'h0123450;
    repeat (8) step();
    check_eq("s3_m1_bursts", gnt_log.size(), MAXO);
    gnt_log.delete();
    repeat (6) step();
    check_eq("s3_m1_stalled", gnt_log.size(), 0);
    bus.m0_arvalid = 1'b1;
    step();
    check_eq("s3_m0_grant", obs_gnt, 2'b01);
    bus.m0_arvalid = 1'b0;
    step();
    bus.axi_rvalid = 1'b1; bus.axi_rid = 8'd1; bus.axi_rlast = 1'b1;
    step();
    bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0;
    gnt_log.delete();
    repeat (2) step();
    ok = (gnt_log.size() != 0);
    if (ok) ok = (gnt_log[0] == 1);
    check_eq("s3_m1_regrant", ok, 1'b1);

    // controller stalls AR; outputs hold, init_done drop does not abort
    do_reset();
    bus.axi_arready = 1'b0;
    bus.m0_araddr = 28'h0ABCDE0; bus.m0_arlen = 8'd15; bus.m0_arvalid = 1'b1;
    step();
    bus.m0_arvalid = 1'b0; bus.m1_arvalid = 1'b1;
    gnt_log.delete();
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus.ddr_init_done = 1'b0;
      step();
      check_eq("s4_hold_araddr", obs_araddr, 32'h00ABCDE0);
      check_eq("s4_hold_arlen", obs_arlen, 8'd15);
    end
    check_eq("s4_no_grant", gnt_log.size(), 0);
    bus.axi_arready = 1'b1;
    step();
    check_eq("s4_accept", arid_log.size(), 1);
    step();
    check_eq("s4_blocked", obs_gnt, 2'b00);
    bus.ddr_init_done = 1'b1;
    step();
    check_eq("s4_m1_grant", obs_gnt, 2'b10);

    // stray rlast sets the sticky error
    do_reset();
    bus.axi_rvalid = 1'b1; bus.axi_rid = 8'd1; bus.axi_rlast = 1'b1;
    step();
    bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0;
    repeat (5) begin
      step();
      check_eq("s5_perr_sticky", obs_perr, 1'b1);
    end
    do_reset();
    step();
    check_eq("s5_perr_cleared", obs_perr, 1'b0);

    // no grants before init completes, then requester 0 first
    do_reset();
    bus.ddr_init_done = 1'b0;
    bus.m0_arvalid = 1'b1; bus.m1_arvalid = 1'b1;
    repeat (4) begin
      step();
      check_eq("s6_no_grant", obs_gnt, 2'b00);
      check_eq("s6_no_arvalid", obs_arvalid, 1'b0);
    end
    bus.ddr_init_done = 1'b1;
    step();
    check_eq("s6_m0_first", obs_gnt, 2'b01);

    // random traffic with one mid-run reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
